// File: rtl/uart_pkg.sv
// Shared types and constants for the UART command path: assembler states,
// the frame-start marker and the baud timing from which the inter-byte
// timeout is derived.
package uart_pkg;

  typedef enum logic [2:0] {
    HUNT,
    OPC,
    DHI,
    DLO,
    CHK
  } asm_state_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  // 19200 baud from a 50 MHz clock: clocks per full bit and per half bit.
  localparam logic [11:0] BAUD_FULL_BIT = 12'hA2C;
  localparam logic [11:0] BAUD_HALF_BIT = 12'h516;

  // Start + 8 data + stop bits make one byte time on the wire.
  localparam int BITS_PER_FRAME  = 10;
  localparam int BYTE_CYC        = BITS_PER_FRAME * int'(BAUD_FULL_BIT);

  // A frame is abandoned after four byte times of silence between bytes.
  localparam int TIMEOUT_BYTES   = 4;
  localparam int TIMEOUT_CYC_DEF = TIMEOUT_BYTES * BYTE_CYC;

  // Frame body is good when opcode, both data bytes and checksum sum to zero mod 256.
  function automatic logic frame_sum_ok(input logic [7:0] opc,
                                        input logic [7:0] dhi,
                                        input logic [7:0] dlo,
                                        input logic [7:0] chk);
    logic [7:0] sum;
    sum = opc + dhi + dlo + chk;
    return (sum == 8'h00);
  endfunction

endpackage

// File: rtl/uart_frame_timer.sv
// Inter-byte watchdog: counts idle clocks while enabled and flags when the
// count has reached LIMIT-1. The owner clears it on every accepted byte.
module uart_frame_timer #(
  parameter int LIMIT = 104160,
  parameter int W     = $clog2(LIMIT)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear has priority, otherwise advance while enabled.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire = (count_q == LAST);

endmodule

// File: rtl/uart_cmd_assembler.sv
// Collects sync + opcode + data_hi + data_lo + checksum from the UART
// receiver and publishes good frames as a sticky 24-bit command.
module uart_cmd_assembler
  import uart_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF,
  parameter int         TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rdy,
  output logic        clr_rdy,
  output logic [7:0]  cmd,
  output logic [15:0] data,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  output logic        cksum_err,
  output logic        timeout_err,
  output logic        overrun
);

  localparam int TO_W = $clog2(TIMEOUT_CYC);

  asm_state_t  state_q, state_d;
  logic        clr_rdy_q, clr_rdy_d;
  logic [7:0]  opc_q, opc_d;
  logic [7:0]  dhi_q, dhi_d;
  logic [7:0]  dlo_q, dlo_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [15:0] data_q, data_d;
  logic        cmd_rdy_q, cmd_rdy_d;
  logic        cksum_err_q, cksum_err_d;
  logic        timeout_err_q, timeout_err_d;
  logic        overrun_q, overrun_d;

  logic take;
  logic in_frame;
  logic expire;
  logic timeout;

  // rdy stays high for one cycle after clr_rdy, so masking with our own
  // pulse gives exactly one take per received byte.
  assign take     = rdy & ~clr_rdy_q;
  assign in_frame = (state_q != HUNT);
  // A byte landing on the limit cycle still counts, so take beats timeout.
  assign timeout  = expire & in_frame & ~take;

  uart_frame_timer #(
    .LIMIT (TIMEOUT_CYC),
    .W     (TO_W)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (take | ~in_frame | timeout),
    .en     (in_frame),
    .expire (expire)
  );

  // Frame FSM, byte capture and result/flag computation.
  always_comb begin
    state_d       = state_q;
    clr_rdy_d     = take;
    opc_d         = opc_q;
    dhi_d         = dhi_q;
    dlo_d         = dlo_q;
    cmd_d         = cmd_q;
    data_d        = data_q;
    cmd_rdy_d     = cmd_rdy_q & ~clr_cmd_rdy;
    cksum_err_d   = 1'b0;
    timeout_err_d = 1'b0;
    overrun_d     = 1'b0;

    if (timeout) begin
      state_d       = HUNT;
      timeout_err_d = 1'b1;
    end else if (take) begin
      case (state_q)
        HUNT: begin
          if (rx_data == SYNC_BYTE) begin
            state_d = OPC;
          end
        end
        OPC: begin
          opc_d   = rx_data;
          state_d = DHI;
        end
        DHI: begin
          dhi_d   = rx_data;
          state_d = DLO;
        end
        DLO: begin
          dlo_d   = rx_data;
          state_d = CHK;
        end
        CHK: begin
          if (frame_sum_ok(opc_q, dhi_q, dlo_q, rx_data)) begin
            cmd_d     = opc_q;
            data_d    = {dhi_q, dlo_q};
            cmd_rdy_d = 1'b1;
            overrun_d = cmd_rdy_q;
          end else begin
            cksum_err_d = 1'b1;
          end
          state_d = HUNT;
        end
        default: begin
          state_d = HUNT;
        end
      endcase
    end
  end

  // State, capture and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= HUNT;
      clr_rdy_q     <= 1'b0;
      opc_q         <= '0;
      dhi_q         <= '0;
      dlo_q         <= '0;
      cmd_q         <= '0;
      data_q        <= '0;
      cmd_rdy_q     <= 1'b0;
      cksum_err_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      clr_rdy_q     <= clr_rdy_d;
      opc_q         <= opc_d;
      dhi_q         <= dhi_d;
      dlo_q         <= dlo_d;
      cmd_q         <= cmd_d;
      data_q        <= data_d;
      cmd_rdy_q     <= cmd_rdy_d;
      cksum_err_q   <= cksum_err_d;
      timeout_err_q <= timeout_err_d;
      overrun_q     <= overrun_d;
    end
  end

  assign clr_rdy     = clr_rdy_q;
  assign cmd         = cmd_q;
  assign data        = data_q;
  assign cmd_rdy     = cmd_rdy_q;
  assign cksum_err   = cksum_err_q;
  assign timeout_err = timeout_err_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_uart_cmd_assembler.sv
// Bench for uart_cmd_assembler: a byte-level receiver driver plus a
// frame-level reference model (a queue of the bytes of the current frame).
module tb_uart_cmd_assembler;

  localparam int T = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rdy = 1'b0;
  logic        clr_cmd_rdy = 1'b0;
  logic        clr_rdy;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        cmd_rdy;
  logic        cksum_err;
  logic        timeout_err;
  logic        overrun;

  int checks = 0;
  int errors = 0;

  logic [7:0]  frame_q[$];
  logic [7:0]  exp_cmd;
  logic [15:0] exp_data;
  logic        exp_rdy;
  logic        exp_ck;
  logic        exp_ov;

  uart_cmd_assembler #(
    .SYNC_BYTE   (8'hA5),
    .TIMEOUT_CYC (T)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rdy         (rdy),
    .clr_rdy     (clr_rdy),
    .cmd         (cmd),
    .data        (data),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .cksum_err   (cksum_err),
    .timeout_err (timeout_err),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    frame_q.delete();
    exp_cmd  = 8'h00;
    exp_data = 16'h0000;
    exp_rdy  = 1'b0;
    exp_ck   = 1'b0;
    exp_ov   = 1'b0;
  endtask

  // Frame-level reference: one accepted byte, optionally with an ack in the same cycle.
  task automatic model_byte(input logic [7:0] b, input logic ack);
    logic [7:0] s;
    logic good;
    good   = 1'b0;
    exp_ck = 1'b0;
    exp_ov = 1'b0;
    if (frame_q.size() == 0) begin
      if (b == 8'hA5) frame_q.push_back(b);
    end else begin
      frame_q.push_back(b);
      if (frame_q.size() == 5) begin
        s = frame_q[1] + frame_q[2] + frame_q[3] + frame_q[4];
        if (s == 8'h00) begin
          exp_ov   = exp_rdy;
          exp_rdy  = 1'b1;
          exp_cmd  = frame_q[1];
          exp_data = {frame_q[2], frame_q[3]};
          good     = 1'b1;
        end else begin
          exp_ck = 1'b1;
        end
        frame_q.delete();
      end
    end
    if (ack && !good) exp_rdy = 1'b0;
  endtask

  // Present one byte after 'idle' quiet cycles, then behave like the receiver.
  task automatic send_byte(input logic [7:0] b, input int idle, input logic ack);
    int n;
    for (int i = 0; i < idle; i++) begin
      @(posedge clk); #1;
      checks++;
      if (timeout_err !== 1'b0) begin
        errors++;
        $display("[TB] FAIL idle_no_timeout: timeout_err=%b required 0 (idle %0d)", timeout_err, i);
      end
    end
    rx_data = b;
    rdy = 1'b1;
    clr_cmd_rdy = ack;
    n = 0;
    do begin
      @(posedge clk); #1;
      clr_cmd_rdy = 1'b0;
      n++;
    end while (clr_rdy !== 1'b1 && n < 8);
    checks++;
    if (clr_rdy !== 1'b1 || n != 1) begin
      errors++;
      $display("[TB] FAIL take_latency: clr_rdy=%b after %0d cycles, required 1 after 1", clr_rdy, n);
      rdy = 1'b0;
      return;
    end
    model_byte(b, ack);
    checks++;
    if ({cmd, data, cmd_rdy, cksum_err, overrun, timeout_err} !==
        {exp_cmd, exp_data, exp_rdy, exp_ck, exp_ov, 1'b0}) begin
      errors++;
      $display("[TB] FAIL byte_result(%h): cmd=%h data=%h rdy=%b ck=%b ov=%b to=%b required cmd=%h data=%h rdy=%b ck=%b ov=%b to=0",
               b, cmd, data, cmd_rdy, cksum_err, overrun, timeout_err,
               exp_cmd, exp_data, exp_rdy, exp_ck, exp_ov);
    end
    @(posedge clk); #1;
    rdy = 1'b0;
    checks++;
    if ({clr_rdy, cksum_err, overrun, timeout_err, cmd_rdy} !== {4'b0000, exp_rdy}) begin
      errors++;
      $display("[TB] FAIL pulse_end(%h): clr_rdy=%b ck=%b ov=%b to=%b rdy=%b required 0 0 0 0 %b",
               b, clr_rdy, cksum_err, overrun, timeout_err, cmd_rdy, exp_rdy);
    end
  endtask

  task automatic send_frame(input logic [39:0] f, input int gap);
    for (int i = 4; i >= 0; i--) begin
      send_byte(f[i*8 +: 8], gap, 1'b0);
    end
  endtask

  task automatic ack_cmd();
    clr_cmd_rdy = 1'b1;
    @(posedge clk); #1;
    clr_cmd_rdy = 1'b0;
    exp_rdy = 1'b0;
    checks++;
    if (cmd_rdy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ack_clears: cmd_rdy=%b required 0", cmd_rdy);
    end
  endtask

  // Waits for a timeout pulse that should arrive T-1 cycles after the last take's clr_rdy cycle.
  task automatic wait_timeout();
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (timeout_err !== 1'b1 && n < 2 * T);
    checks++;
    if (timeout_err !== 1'b1 || n != T - 1) begin
      errors++;
      $display("[TB] FAIL timeout_timing: timeout_err=%b after %0d cycles, required 1 after %0d", timeout_err, n, T - 1);
    end
    frame_q.delete();
    @(posedge clk); #1;
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL timeout_pulse_width: timeout_err=%b required 0", timeout_err);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2 rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({clr_rdy, cmd, data, cmd_rdy, cksum_err, overrun, timeout_err} !== 29'h0) begin
      errors++;
      $display("[TB] FAIL reset_values: outputs=%h required 0",
               {clr_rdy, cmd, data, cmd_rdy, cksum_err, overrun, timeout_err});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_good_frame();
    send_frame(40'hA5_10_12_34_AA, 0);
    checks++;
    if ({cmd, data, cmd_rdy} !== {8'h10, 16'h1234, 1'b1}) begin
      errors++;
      $display("[TB] FAIL good_frame: cmd=%h data=%h rdy=%b required 10 1234 1", cmd, data, cmd_rdy);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (cmd_rdy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL cmd_rdy_sticky: cmd_rdy=%b required 1", cmd_rdy);
    end
    ack_cmd();
  endtask

  task automatic test_bad_checksum();
    send_frame(40'hA5_10_12_34_AB, 0);
    checks++;
    if ({cmd, data, cmd_rdy} !== {8'h10, 16'h1234, 1'b0}) begin
      errors++;
      $display("[TB] FAIL bad_cksum_hold: cmd=%h data=%h rdy=%b required 10 1234 0", cmd, data, cmd_rdy);
    end
    send_frame(40'hA5_01_00_00_FF, 1);
    checks++;
    if ({cmd, data, cmd_rdy} !== {8'h01, 16'h0000, 1'b1}) begin
      errors++;
      $display("[TB] FAIL after_bad_cksum: cmd=%h data=%h rdy=%b required 01 0000 1", cmd, data, cmd_rdy);
    end
    ack_cmd();
  endtask

  task automatic test_hunt_false_sync();
    logic [7:0] seq [7];
    seq = '{8'h33, 8'h7E, 8'hA5, 8'hA5, 8'h00, 8'h01, 8'h5A};
    foreach (seq[i]) send_byte(seq[i], 0, 1'b0);
    checks++;
    if ({cmd, data, cmd_rdy} !== {8'hA5, 16'h0001, 1'b1}) begin
      errors++;
      $display("[TB] FAIL false_sync: cmd=%h data=%h rdy=%b required A5 0001 1", cmd, data, cmd_rdy);
    end
    ack_cmd();
  endtask

  task automatic test_timeout();
    send_byte(8'hA5, 0, 1'b0);
    send_byte(8'h10, 0, 1'b0);
    wait_timeout();
    send_frame(40'hA5_20_00_00_E0, 0);
    ack_cmd();
    // Byte arrives exactly on the limit cycle and must be accepted.
    send_byte(8'hA5, 0, 1'b0);
    send_byte(8'h10, T - 2, 1'b0);
    send_byte(8'h12, T - 2, 1'b0);
    send_byte(8'h34, 0, 1'b0);
    send_byte(8'hAA, 0, 1'b0);
    checks++;
    if ({cmd, data, cmd_rdy} !== {8'h10, 16'h1234, 1'b1}) begin
      errors++;
      $display("[TB] FAIL limit_take: cmd=%h data=%h rdy=%b required 10 1234 1", cmd, data, cmd_rdy);
    end
    ack_cmd();
  endtask

  task automatic test_overrun_ack_race();
    send_frame(40'hA5_10_12_34_AA, 0);
    send_frame(40'hA5_20_00_00_E0, 0);
    checks++;
    if ({cmd, data, cmd_rdy} !== {8'h20, 16'h0000, 1'b1}) begin
      errors++;
      $display("[TB] FAIL overrun_data: cmd=%h data=%h rdy=%b required 20 0000 1", cmd, data, cmd_rdy);
    end
    ack_cmd();
    send_byte(8'hA5, 0, 1'b0);
    send_byte(8'h01, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'hFF, 0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (cmd_rdy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ack_race: cmd_rdy=%b required 1", cmd_rdy);
    end
    ack_cmd();
  endtask

  task automatic test_reset_mid_frame();
    int n;
    send_frame(40'hA5_10_12_34_AA, 0);
    send_byte(8'hA5, 0, 1'b0);
    send_byte(8'h10, 0, 1'b0);
    rx_data = 8'h12;
    rdy = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (clr_rdy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL pre_reset_take: clr_rdy=%b required 1", clr_rdy);
    end
    #2 rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if ({clr_rdy, cmd, data, cmd_rdy, cksum_err, overrun, timeout_err} !== 29'h0) begin
      errors++;
      $display("[TB] FAIL mid_frame_reset: outputs=%h required 0",
               {clr_rdy, cmd, data, cmd_rdy, cksum_err, overrun, timeout_err});
    end
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (clr_rdy !== 1'b1 && n < 8);
    checks++;
    if (clr_rdy !== 1'b1 || n != 1) begin
      errors++;
      $display("[TB] FAIL retake_after_reset: clr_rdy=%b after %0d cycles, required 1 after 1", clr_rdy, n);
    end
    model_byte(8'h12, 1'b0);
    @(posedge clk); #1;
    rdy = 1'b0;
    send_frame(40'hA5_55_AA_00_01, 0);
    checks++;
    if ({cmd, data, cmd_rdy, overrun} !== {8'h55, 16'hAA00, 1'b1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL post_reset_frame: cmd=%h data=%h rdy=%b ov=%b required 55 AA00 1 0", cmd, data, cmd_rdy, overrun);
    end
    ack_cmd();
  endtask

  task automatic test_random();
    logic [7:0] opc, dhi, dlo, chk, junk;
    int cut;
    for (int f = 0; f < 40; f++) begin
      for (int j = 0; j < $urandom_range(0, 2); j++) begin
        junk = 8'($urandom);
        if (junk == 8'hA5) junk = 8'h5A;
        send_byte(junk, $urandom_range(0, 3), 1'b0);
      end
      opc = 8'($urandom);
      dhi = 8'($urandom);
      dlo = 8'($urandom);
      chk = 8'h00 - opc - dhi - dlo;
      if ($urandom_range(0, 3) == 0) chk = chk + 8'($urandom_range(1, 255));
      cut = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 4) : 5;
      if (cut >= 1) send_byte(8'hA5, $urandom_range(0, 5), $urandom_range(0, 3) == 0);
      if (cut >= 2) send_byte(opc, $urandom_range(0, 5), $urandom_range(0, 3) == 0);
      if (cut >= 3) send_byte(dhi, $urandom_range(0, 5), $urandom_range(0, 3) == 0);
      if (cut >= 4) send_byte(dlo, $urandom_range(0, 5), $urandom_range(0, 3) == 0);
      if (cut >= 5) send_byte(chk, $urandom_range(0, 5), $urandom_range(0, 3) == 0);
      else wait_timeout();
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_hunt_false_sync();
    test_timeout();
    test_overrun_ack_race();
    test_reset_mid_frame();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
